// File: rtl/window_readout_pkg.sv
// Shared types and helpers for the window readout block.
// Holds the readout FSM state encoding and the pointer-width helper.
// No logic of its own.
package window_readout_pkg;

    typedef enum logic [1:0] {
        ST_FILL    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_READOUT = 2'd2
    } state_e;

    // Pointer width for a power-of-two window length.
    function automatic int ptr_width(input int len);
        return $clog2(len);
    endfunction

endpackage

// File: rtl/window_readout_sdp_ram.sv
// Inferred simple dual-port RAM: one write port, one read port.
// Latency: read data registered, available 1 cycle after re_i.
// Backpressure: none; rdata_o holds its value while re_i is low.
module sdp_ram #(
    parameter int DATA_WIDTH = 25,
    parameter int DEPTH      = 512,
    parameter int AW         = 9
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [AW-1:0]         waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [AW-1:0]         raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // storage write and registered read; contents are never reset
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_o <= mem[raddr_i];
        end
    end

endmodule

// File: rtl/window_readout.sv
// Circular capture buffer; on trig emits the last LEN samples, oldest first.
// Latency: first data_valid 2 cycles after trig, then 1 sample/cycle with data_ready high.
// Backpressure: data_ready low stalls output (held stable); writes discarded during readout.
// Optional feature macro: WINDOW_READOUT_DROP_CNT_EN (drop counter on drop_cnt).
module window_readout
    import window_readout_pkg::*;
#(
    parameter int DATA_WIDTH = 25,
    parameter int LEN        = 512
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] di,
    input  logic                  di_valid,
    input  logic                  trig,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  data_valid,
    input  logic                  data_ready,
    output logic                  data_last,
    output logic                  full,
    output logic                  busy,
    output logic [15:0]           drop_cnt
);

    localparam int              AW        = ptr_width(LEN);
    localparam logic [AW:0]     LEN_C     = (AW+1)'(LEN);
    localparam logic [AW:0]     FILL_LAST = (AW+1)'(LEN - 1);
    localparam logic [AW-1:0]   LAST_IDX  = AW'(LEN - 1);
    localparam logic [AW-1:0]   PTR_ONE   = AW'(1);
    localparam logic [AW:0]     CNT_ONE   = (AW+1)'(1);

    state_e                state_q, state_d;
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW:0]           fill_q, fill_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [AW:0]           rd_cnt_q, rd_cnt_d;    // RAM reads issued this window
    logic                  rv_q, rv_d;            // RAM read data valid this cycle
    logic [AW-1:0]         out_cnt_q, out_cnt_d;  // samples transferred this window
    logic [1:0]            sk_cnt_q, sk_cnt_d;
    logic [DATA_WIDTH-1:0] sk0_q, sk0_d, sk1_q, sk1_d;

    logic                  wr_en;
    logic                  start;
    logic                  pop;
    logic                  last_pop;
    logic [2:0]            occ;
    logic                  rd_issue;
    logic [AW-1:0]         rd_addr;
    logic [1:0]            wi;
    logic [DATA_WIDTH-1:0] ram_rdata;

    assign wr_en    = di_valid && (state_q != ST_READOUT);
    assign wr_ptr_d = wr_en ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    // A same-cycle write lands at wr_ptr_q, so the oldest sample is at wr_ptr_d.
    assign start    = (state_q == ST_ARMED) && trig;

    assign data_valid = (sk_cnt_q != 2'd0);
    assign data_o     = sk0_q;
    assign data_last  = data_valid && (out_cnt_q == LAST_IDX);
    assign pop        = data_valid && data_ready;
    assign last_pop   = pop && data_last;
    assign full       = (fill_q == LEN_C);
    assign busy       = (state_q == ST_READOUT);

    // Entries held or in flight after this cycle; a read is issued only if it still fits.
    assign occ      = {1'b0, sk_cnt_q} + {2'b00, rv_q} - {2'b00, pop};
    assign rd_issue = start ||
                      ((state_q == ST_READOUT) && (rd_cnt_q != LEN_C) && (occ < 3'd2));
    assign rd_addr  = start ? wr_ptr_d : rd_ptr_q;
    assign wi       = sk_cnt_q - {1'b0, pop};

    sdp_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (LEN),
        .AW         (AW)
    ) u_ram (
        .clk     (clk),
        .we_i    (wr_en),
        .waddr_i (wr_ptr_q),
        .wdata_i (di),
        .re_i    (rd_issue),
        .raddr_i (rd_addr),
        .rdata_o (ram_rdata)
    );

    // FSM next state: fill up, wait for trigger, stream the window out
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FILL:    if (wr_en && (fill_q == FILL_LAST)) state_d = ST_ARMED;
            ST_ARMED:   if (trig) state_d = ST_READOUT;
            ST_READOUT: if (last_pop) state_d = ST_FILL;
            default:    state_d = ST_FILL;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // datapath next state: pointers, counters and the 2-entry output skid buffer
    always_comb begin
        fill_d    = fill_q;
        rd_ptr_d  = rd_ptr_q;
        rd_cnt_d  = rd_cnt_q;
        rv_d      = rd_issue;
        out_cnt_d = out_cnt_q;
        sk0_d     = sk0_q;
        sk1_d     = sk1_q;
        sk_cnt_d  = sk_cnt_q + {1'b0, rv_q} - {1'b0, pop};

        if ((state_q == ST_FILL) && wr_en) begin
            fill_d = fill_q + CNT_ONE;
        end

        if (start) begin
            rd_ptr_d = wr_ptr_d + PTR_ONE;
            rd_cnt_d = CNT_ONE;
        end else if (rd_issue) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            rd_cnt_d = rd_cnt_q + CNT_ONE;
        end

        if (pop) begin
            sk0_d     = sk1_q;
            out_cnt_d = out_cnt_q + PTR_ONE;
        end
        if (rv_q) begin
            if (wi == 2'd0) sk0_d = ram_rdata;
            else            sk1_d = ram_rdata;
        end

        if (last_pop) begin
            fill_d    = '0;
            rd_cnt_d  = '0;
            out_cnt_d = '0;
        end
    end

    // datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            fill_q    <= '0;
            rd_ptr_q  <= '0;
            rd_cnt_q  <= '0;
            rv_q      <= 1'b0;
            out_cnt_q <= '0;
            sk_cnt_q  <= 2'd0;
            sk0_q     <= '0;
            sk1_q     <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            fill_q    <= fill_d;
            rd_ptr_q  <= rd_ptr_d;
            rd_cnt_q  <= rd_cnt_d;
            rv_q      <= rv_d;
            out_cnt_q <= out_cnt_d;
            sk_cnt_q  <= sk_cnt_d;
            sk0_q     <= sk0_d;
            sk1_q     <= sk1_d;
        end
    end

`ifdef WINDOW_READOUT_DROP_CNT_EN
    logic [15:0] drop_q, drop_d;

    // saturating count of samples discarded while a window is being read out
    always_comb begin
        drop_d = drop_q;
        if ((state_q == ST_READOUT) && di_valid && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
        end
    end

    // drop counter register, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_q <= 16'd0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign drop_cnt = drop_q;
`else
    assign drop_cnt = 16'd0;
`endif

endmodule

// File: doc/window_readout.md
WINDOW_READOUT -- requirements
Module: window_readout

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 25, sample width in bits.
REQ-002 SHALL have parameter LEN, default 512, window length in samples; power of two, 4..4096.
REQ-003 SHALL have port clk  input  1  the single clock; all logic rising-edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port di  input  DATA_WIDTH  input sample.
REQ-006 SHALL have port di_valid  input  1  di is written this cycle.
REQ-007 SHALL have port trig  input  1  single-cycle readout request.
REQ-008 SHALL have port data_o  output  DATA_WIDTH  readout sample.
REQ-009 SHALL have port data_valid  output  1  data_o holds a valid sample.
REQ-010 SHALL have port data_ready  input  1  downstream accepts data_o.
REQ-011 SHALL have port data_last  output  1  marks the final sample of a window.
REQ-012 SHALL have port full  output  1  LEN samples are held since the last readout or reset.
REQ-013 SHALL have port busy  output  1  readout in progress.
REQ-014 SHALL have port drop_cnt  output  16  samples discarded during readout.

Function
REQ-015 SHALL store samples in a LEN-deep circular buffer: write pointer advances mod LEN on each accepted di_valid.
REQ-016 SHALL use an FSM with states FILL, ARMED and READOUT.
REQ-017 FILL: accept writes; count the fill level, saturating at LEN; on reaching LEN raise full and go to ARMED.
REQ-018 ARMED: keep accepting writes; overwrite the oldest sample; full stays 1.
REQ-019 trig in ARMED SHALL go to READOUT next cycle; trig in FILL or READOUT SHALL be ignored.
REQ-020 trig and di_valid in the same cycle in ARMED: that sample is written and is the newest sample of the window.
REQ-021 READOUT: writes are blocked and di_valid is discarded; busy = 1.
REQ-022 READOUT SHALL emit exactly LEN samples, oldest first, ending with the newest; the start read address is the write pointer at trigger.
REQ-023 Handshake: a transfer occurs when data_valid and data_ready are both 1.
REQ-024 While data_valid = 1 and data_ready = 0, data_o, data_valid and data_last SHALL hold stable.
REQ-025 First data_valid SHALL assert 2 cycles after the trig cycle.
REQ-026 With data_ready held 1, data_valid SHALL stay 1 for LEN consecutive cycles with no bubbles; RAM read latency is absorbed by a 2-entry output skid buffer.
REQ-027 data_last = 1 only with the LEN-th sample.
REQ-028 After the data_last transfer, the block SHALL clear the fill level and full, deassert busy, and enter FILL the next cycle; write-pointer continuity is preserved.
REQ-029 Read-address arithmetic SHALL be modulo LEN with log2(LEN)-bit pointers; wrap from LEN-1 to 0 needs no special case.

Reset
REQ-030 While rst_n = 0: state is FILL; pointers and fill level are 0; data_valid, data_last, full and busy are 0; drop_cnt is 0. RAM contents are not reset.
REQ-031 Reset asserted mid-readout SHALL abort the window immediately; no further data_valid until a new trigger.

Configuration
REQ-032 Macro WINDOW_READOUT_DROP_CNT_EN:
- Defined: drop_cnt increments on each di_valid in READOUT and saturates at 65535. It clears only on reset.
- Undefined: drop_cnt is constant 0 and the counter is not built.

Structure
REQ-033 Package window_readout_pkg SHALL hold the state enum type and a constant function for the pointer width, log2(LEN).
REQ-034 A sub-module sdp_ram SHALL be an inferred simple dual-port RAM with one write port, one read port and 1-cycle registered read. No vendor primitives.

Verification (DATA_WIDTH=25, LEN=8)
REQ-035 Reset, then write 1..5, then trig -> full = 0, trig ignored, data_valid stays 0.
REQ-036 Write 1..8 -> full = 1 after the 8th write. trig -> data_o = 1..8 on 8 consecutive cycles, data_last with 8, first data_valid 2 cycles after trig.
REQ-037 Write 1..11, trig, data_ready = 1 -> output is 4..11, exercising wrap-around.
REQ-038 Write 1..8, trig, data_ready toggled 1,0,0,1,... -> data_o holds while stalled; sequence 1..8 with no loss or duplication.
REQ-039 During readout, drive 3 di_valid -> samples absent from the next window. drop_cnt = 3 with the macro defined, 0 without.
REQ-040 Assert rst_n = 0 after the 3rd transfer of a window -> data_valid = 0 the same cycle, state FILL, full = 0.
